// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with PC register, IF/ID pipeline
//               register, branch redirect, hazard stall and flush counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [63:0] branch_target,
  input  logic        stall,
  input  logic [31:0] instr_in,
  output logic [63:0] pc_out,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [15:0] flush_count
);

  // Low PC bits are forced to zero even if RESET_PC is misaligned.
  localparam logic [63:0] c_reset_pc  = {RESET_PC[63:2], 2'b00};
  localparam logic [15:0] c_count_max = 16'hFFFF;

  logic [63:0] r_pc;
  logic [63:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic [15:0] r_flush_count;

  logic [63:0] w_redirect_pc;
  logic [63:0] w_seq_pc;

  assign w_redirect_pc = {branch_target[63:2], 2'b00};
  assign w_seq_pc      = r_pc + 64'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= c_reset_pc;
      r_ifid_pc     <= 64'h0;
      r_ifid_instr  <= NOP_INSTR;
      r_ifid_valid  <= 1'b0;
      r_flush_count <= 16'h0;
    end else if (flush) begin
      r_pc          <= w_redirect_pc;
      r_ifid_pc     <= r_pc;
      r_ifid_instr  <= NOP_INSTR;
      r_ifid_valid  <= 1'b0;
      if (r_flush_count != c_count_max) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end else if (!stall) begin
      r_pc          <= w_seq_pc;
      r_ifid_pc     <= r_pc;
      r_ifid_instr  <= instr_in;
      r_ifid_valid  <= 1'b1;
    end
  end

  assign pc_out      = r_pc;
  assign ifid_pc     = r_ifid_pc;
  assign ifid_instr  = r_ifid_instr;
  assign ifid_valid  = r_ifid_valid;
  assign flush_count = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed scoreboard bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [63:0] c_reset_pc = 64'h0;
  localparam logic [31:0] c_nop      = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        stall = 1'b0;
  logic [31:0] instr_in = 32'h0;
  logic [63:0] pc_out;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [15:0] flush_count;

  fetch_stage #(
    .RESET_PC (c_reset_pc),
    .NOP_INSTR(c_nop)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .branch_target(branch_target),
    .stall        (stall),
    .instr_in     (instr_in),
    .pc_out       (pc_out),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] ipc;
    logic [31:0] ins;
    logic        v;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];

  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_ins;
  logic        m_v;
  logic [15:0] m_fc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare after the edge.
  task automatic step(input logic r, input logic f, input logic s,
                      input logic [63:0] bt, input logic [31:0] ins,
                      input string tag);
    exp_t e;
    reset = r; flush = f; stall = s; branch_target = bt; instr_in = ins;
    if (r) begin
      m_pc = c_reset_pc; m_ipc = 64'h0; m_ins = c_nop; m_v = 1'b0; m_fc = 16'h0;
    end else if (f) begin
      m_ipc = m_pc; m_pc = {bt[63:2], 2'b00}; m_ins = c_nop; m_v = 1'b0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end else if (!s) begin
      m_ipc = m_pc; m_ins = ins; m_v = 1'b1; m_pc = m_pc + 64'd4;
    end
    sb.push_back('{pc: m_pc, ipc: m_ipc, ins: m_ins, v: m_v, fc: m_fc});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc_out"},      pc_out,              e.pc);
    chk({tag, ".ifid_pc"},     ifid_pc,             e.ipc);
    chk({tag, ".ifid_instr"},  {32'h0, ifid_instr}, {32'h0, e.ins});
    chk({tag, ".ifid_valid"},  {63'h0, ifid_valid}, {63'h0, e.v});
    chk({tag, ".flush_count"}, {48'h0, flush_count}, {48'h0, e.fc});
  endtask

  initial begin
    m_pc = 'x; m_ipc = 'x; m_ins = 'x; m_v = 1'bx; m_fc = 'x;
    @(negedge clk);

    step(1, 0, 0, 64'h0,   32'h0, "reset0");
    step(1, 1, 1, 64'h500, 32'h0, "reset_ff");

    // Sequential fetch
    step(0, 0, 0, 64'h0, 32'hA, "adv_a");
    step(0, 0, 0, 64'h0, 32'hB, "adv_b");
    step(0, 0, 0, 64'h0, 32'hC, "adv_c");
    step(0, 0, 0, 64'h0, 32'hD, "adv_d");

    // Redirect with misaligned target, then the bubble drains
    step(0, 1, 0, 64'h103, 32'hFF, "flush_103");
    step(0, 0, 0, 64'h0,   32'hE,  "adv_after_flush");

    // Two-cycle stall at pc 0x8
    step(0, 1, 0, 64'h8, 32'h0,  "flush_8");
    step(0, 0, 0, 64'h0, 32'h21, "adv_8");
    step(0, 1, 0, 64'h8, 32'h0,  "flush_8b");
    step(0, 0, 1, 64'h0, 32'h31, "stall1");
    step(0, 0, 1, 64'h0, 32'h32, "stall2");
    step(0, 0, 0, 64'h0, 32'h33, "release");

    // Flush wins over stall; flush to the current pc; back-to-back flushes
    step(0, 1, 1, 64'h40,  32'h0,  "flush_stall");
    step(0, 1, 0, 64'h40,  32'h0,  "flush_same_pc");
    step(0, 1, 0, 64'h201, 32'h0,  "b2b_1");
    step(0, 1, 0, 64'h302, 32'h0,  "b2b_2");
    step(0, 0, 0, 64'h0,   32'h44, "adv_b2b");

    // Reset during stall and during flush
    step(0, 1, 0, 64'h20,  32'h0,  "flush_20");
    step(0, 0, 1, 64'h0,   32'h55, "stall_20");
    step(1, 0, 1, 64'h0,   32'h0,  "reset_stall");
    step(1, 1, 0, 64'h700, 32'h0,  "reset_flush");
    step(0, 0, 0, 64'h0,   32'h66, "adv_from_reset");

    // PC wrap
    step(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,  "flush_top");
    step(0, 0, 0, 64'h0,                   32'h77, "wrap");
    step(0, 0, 0, 64'h0,                   32'h78, "after_wrap");

    // Flush counter saturation
    step(1, 0, 0, 64'h0, 32'h0, "reset_sat");
    for (int i = 0; i < 65538; i++) begin
      step(0, 1, 0, 64'(i) << 2, 32'h0, "sat_flush");
    end
    step(0, 0, 0, 64'h0, 32'h99, "sat_adv");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
